// File: rtl/sha_hasher.sv
// ---------------------------------------------------------------------------
// sha_hasher
// Bitcoin proof-of-work search engine. Walks nonce (and time on nonce wrap)
// over a fixed block-header tail and evaluates SHA256d with a fully unrolled
// pipeline: one register stage per compression round, one candidate per clock.
// A candidate whose byte-reversed digest is below the compact target is a hit.
//
// Ports
//   CLK            clock, rising edge
//   RST            synchronous active-low reset; loads the start counters
//   write_en       1 = inject one candidate this clock
//   digest_intial  H0..H7 after chunk 1 (H0 in MSBs), chunk-2 feed-forward
//   digest_in      chunk-2 working state a..h after round 0 (a in MSBs)
//   merkle_in      chunk-2 W0
//   time_in        start time (chunk-2 W1)
//   target_in      compact nBits as header bytes (byte-reversed nBits)
//   nonce_in       start nonce (chunk-2 W3)
//   valid_out      one-cycle pulse per registered hit
//   time_out       time of last hit
//   nonce_out      nonce of last hit
//   result_out     final digest H0..H7 of last hit (H0 in MSBs)
//
// Stage map (candidate captured into stage 0 at edge k, stage s at edge k+s):
//   0        counters + chunk-2 window W1..W16, state = digest_in
//   1..63    chunk-2 rounds 1..63
//   64       chunk-2 feed-forward; loads second-hash window and IV
//   65..128  second-hash rounds 0..63
//   129      second-hash feed-forward (final digest)
//   output registers update at edge k+130
// The message window always holds the next 16 schedule words with the word
// the next round consumes in the top slot, so each stage only needs one new
// schedule word.
// ---------------------------------------------------------------------------
module sha_hasher (
    input  logic         CLK,
    input  logic         RST,
    input  logic         write_en,
    input  logic [255:0] digest_intial,
    input  logic [255:0] digest_in,
    input  logic [31:0]  merkle_in,
    input  logic [31:0]  time_in,
    input  logic [31:0]  target_in,
    input  logic [31:0]  nonce_in,
    output logic         valid_out,
    output logic [31:0]  time_out,
    output logic [31:0]  nonce_out,
    output logic [255:0] result_out
);

    localparam int B_LOAD = 64;
    localparam int B_LAST = 128;
    localparam int FINAL  = 129;

    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [2047:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3'd3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 4'd10);
    endfunction

    // One SHA-256 compression round on packed state a..h (a in MSBs).
    function automatic logic [255:0] sha_round(input logic [255:0] st, input logic [31:0] w,
                                               input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + (rotr(e, 5'd6) ^ rotr(e, 5'd11) ^ rotr(e, 5'd25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 5'd2) ^ rotr(a, 5'd13) ^ rotr(a, 5'd22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Drop the consumed top word and append the next schedule word.
    function automatic logic [511:0] win_shift(input logic [511:0] w);
        logic [31:0] nw;
        nw = ssig1(w[63:32]) + w[223:192] + ssig0(w[479:448]) + w[511:480];
        return {w[479:0], nw};
    endfunction

    // Word-wise modular add of two 8-word digests.
    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    logic [31:0]    time_cnt_r;
    logic [31:0]    nonce_cnt_r;
    logic [FINAL:0] valid_r;
    logic [255:0]   state_r [0:FINAL];
    logic [511:0]   win_r   [0:B_LAST];
    logic [31:0]    time_r  [0:FINAL];
    logic [31:0]    nonce_r [0:FINAL];

    logic [31:0]    nbits_s;
    logic [255:0]   mant_s;
    logic [255:0]   target_s;
    logic [255:0]   hash_num_s;
    logic           hit_s;

    // Search counters and the valid shift chain; reset loads the start point
    // and invalidates every in-flight candidate.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            time_cnt_r  <= time_in;
            nonce_cnt_r <= nonce_in;
            valid_r     <= {(FINAL + 1){1'b0}};
        end else begin
            valid_r <= {valid_r[FINAL-1:0], write_en};
            if (write_en) begin
                nonce_cnt_r <= nonce_cnt_r + 32'd1;
                if (nonce_cnt_r == 32'hFFFF_FFFF) begin
                    time_cnt_r <= time_cnt_r + 32'd1;
                end
            end
        end
    end

    // Stage 0: capture the candidate and build its chunk-2 window W1..W16.
    // W5..W14 are zero, so W16 reduces to ssig0(W1) + W0.
    always_ff @(posedge CLK) begin
        time_r[0]  <= time_cnt_r;
        nonce_r[0] <= nonce_cnt_r;
        state_r[0] <= digest_in;
        win_r[0]   <= {time_cnt_r, target_in, nonce_cnt_r, 32'h8000_0000, 320'd0,
                       32'h0000_0280, ssig0(time_cnt_r) + merkle_in};
    end

    genvar s;
    generate
        for (s = 1; s <= FINAL; s = s + 1) begin : g_stage
            if (s == B_LOAD) begin : g_load
                // Chunk-2 feed-forward; the result becomes the second hash's message.
                always_ff @(posedge CLK) begin
                    time_r[s]  <= time_r[s-1];
                    nonce_r[s] <= nonce_r[s-1];
                    state_r[s] <= SHA_IV;
                    win_r[s]   <= {add8(state_r[s-1], digest_intial), 32'h8000_0000, 192'd0, 32'h0000_0100};
                end
            end else if (s == FINAL) begin : g_final
                // Second-hash feed-forward yields the final digest.
                always_ff @(posedge CLK) begin
                    time_r[s]  <= time_r[s-1];
                    nonce_r[s] <= nonce_r[s-1];
                    state_r[s] <= add8(state_r[s-1], SHA_IV);
                end
            end else begin : g_round
                localparam int KI = (s < B_LOAD) ? s : s - B_LOAD - 1;
                // One compression round, consuming the window's top word.
                always_ff @(posedge CLK) begin
                    time_r[s]  <= time_r[s-1];
                    nonce_r[s] <= nonce_r[s-1];
                    state_r[s] <= sha_round(state_r[s-1], win_r[s-1][511:480], K_TABLE[2047 - 32*KI -: 32]);
                    win_r[s]   <= win_shift(win_r[s-1]);
                end
            end
        end
    endgenerate

    // Compact-target decode and hit compare on the final digest.
    always_comb begin
        nbits_s    = {target_in[7:0], target_in[15:8], target_in[23:16], target_in[31:24]};
        mant_s     = {232'd0, nbits_s[23:0]};
        hash_num_s = 256'd0;
        if (nbits_s[31:24] > 8'd32) begin
            target_s = {256{1'b1}};
        end else if (nbits_s[31:24] >= 8'd3) begin
            target_s = mant_s << {nbits_s[31:24] - 8'd3, 3'b000};
        end else begin
            target_s = mant_s >> {8'd3 - nbits_s[31:24], 3'b000};
        end
        for (int i = 0; i < 32; i++) begin
            hash_num_s[8*i +: 8] = state_r[FINAL][255 - 8*i -: 8];
        end
        hit_s = valid_r[FINAL] & (hash_num_s < target_s);
    end

    // Result registers: capture on a hit, otherwise hold the last hit.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            valid_out  <= 1'b0;
            time_out   <= 32'd0;
            nonce_out  <= 32'd0;
            result_out <= 256'd0;
        end else if (hit_s) begin
            valid_out  <= 1'b1;
            time_out   <= time_r[FINAL];
            nonce_out  <= nonce_r[FINAL];
            result_out <= state_r[FINAL];
        end else begin
            valid_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha_hasher.sv
// ---------------------------------------------------------------------------
// tb_sha_hasher
// Scoreboard bench for sha_hasher. The stimulus process tracks the search
// counters itself, hashes every injected candidate with a plain SHA256d
// model, and queues the expected hit with the edge it must appear on. A
// monitor on the falling edge pops and compares hits, and otherwise checks
// that the outputs hold the last hit (or zero after reset).
// ---------------------------------------------------------------------------
module tb_sha_hasher;

    logic         CLK = 1'b0;
    logic         RST;
    logic         write_en;
    logic [255:0] digest_intial;
    logic [255:0] digest_in;
    logic [31:0]  merkle_in;
    logic [31:0]  time_in;
    logic [31:0]  target_in;
    logic [31:0]  nonce_in;
    logic         valid_out;
    logic [31:0]  time_out;
    logic [31:0]  nonce_out;
    logic [255:0] result_out;

    sha_hasher dut (
        .CLK(CLK), .RST(RST), .write_en(write_en),
        .digest_intial(digest_intial), .digest_in(digest_in),
        .merkle_in(merkle_in), .time_in(time_in), .target_in(target_in),
        .nonce_in(nonce_in), .valid_out(valid_out), .time_out(time_out),
        .nonce_out(nonce_out), .result_out(result_out));

    always #5 CLK = ~CLK;

    int edge_cnt = 0;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef logic [31:0] word_t;
    typedef word_t block_t [16];
    typedef struct {
        int           edge_no;
        logic [255:0] res;
        logic [31:0]  t;
        logic [31:0]  n;
    } hit_t;

    hit_t         q[$];
    bit           rst_edge [0:8191];
    logic [255:0] hold_res = 256'd0;
    logic [31:0]  hold_t   = 32'd0;
    logic [31:0]  hold_n   = 32'd0;
    logic [31:0]  m_time;
    logic [31:0]  m_nonce;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [2047:0] KT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h want %h", name, edge_cnt, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic word_t rr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Rounds first..63 of a textbook SHA-256 compression, no feed-forward.
    function automatic logic [255:0] compress(input logic [255:0] st, input block_t m, input int first);
        word_t w [64];
        word_t v [8];
        word_t t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int j = 0; j < 8; j++) v[j] = st[255 - 32*j -: 32];
        for (int i = first; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
               + KT[2047 - 32*i -: 32] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = v[j];
        return r;
    endfunction

    function automatic logic [255:0] wadd(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
        return r;
    endfunction

    function automatic logic [255:0] model_stage_a(input word_t t, input word_t n);
        block_t m;
        for (int i = 0; i < 16; i++) m[i] = 32'd0;
        m[0] = merkle_in; m[1] = t; m[2] = target_in; m[3] = n;
        m[4] = 32'h80000000; m[15] = 32'h00000280;
        return wadd(compress(digest_in, m, 1), digest_intial);
    endfunction

    function automatic logic [255:0] model_final(input logic [255:0] da);
        block_t m;
        for (int i = 0; i < 8; i++) m[i] = da[255 - 32*i -: 32];
        for (int i = 8; i < 16; i++) m[i] = 32'd0;
        m[8] = 32'h80000000; m[15] = 32'h00000100;
        return wadd(compress(IV, m, 0), IV);
    endfunction

    function automatic logic [255:0] byte_rev(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = d[255 - 8*i -: 8];
        return r;
    endfunction

    // Target value from the header-order nBits word, by repeated scaling.
    function automatic logic [255:0] model_target(input word_t tin);
        word_t nb;
        int e;
        logic [255:0] t;
        nb = {tin[7:0], tin[15:8], tin[23:16], tin[31:24]};
        e  = int'(nb[31:24]);
        t  = {232'd0, nb[23:0]};
        if (e > 32) return {256{1'b1}};
        if (e >= 3) repeat (e - 3) t = t * 256;
        else        repeat (3 - e) t = t / 256;
        return t;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (edge_cnt >= 1 && edge_cnt < 8192) begin
            if (rst_edge[edge_cnt]) begin
                hold_res = 256'd0; hold_t = 32'd0; hold_n = 32'd0;
                chk("reset_valid",  {255'd0, valid_out}, 256'd0);
                chk("reset_result", result_out, 256'd0);
                chk("reset_nonce",  {224'd0, nonce_out}, 256'd0);
                chk("reset_time",   {224'd0, time_out}, 256'd0);
            end else if (q.size() > 0 && q[0].edge_no == edge_cnt) begin
                chk("hit_valid",  {255'd0, valid_out}, 256'd1);
                chk("hit_result", result_out, q[0].res);
                chk("hit_nonce",  {224'd0, nonce_out}, {224'd0, q[0].n});
                chk("hit_time",   {224'd0, time_out}, {224'd0, q[0].t});
                hold_res = q[0].res; hold_t = q[0].t; hold_n = q[0].n;
                void'(q.pop_front());
            end else begin
                chk("idle_valid",  {255'd0, valid_out}, 256'd0);
                chk("hold_result", result_out, hold_res);
                chk("hold_nonce",  {224'd0, nonce_out}, {224'd0, hold_n});
                chk("hold_time",   {224'd0, time_out}, {224'd0, hold_t});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst_v, input logic we_v);
        int e;
        logic [255:0] d;
        hit_t h;
        RST = rst_v;
        write_en = we_v;
        e = edge_cnt + 1;
        if (!rst_v) begin
            rst_edge[e] = 1'b1;
            m_time  = time_in;
            m_nonce = nonce_in;
            while (q.size() > 0 && q[q.size()-1].edge_no >= e) void'(q.pop_back());
        end else if (we_v) begin
            d = model_final(model_stage_a(m_time, m_nonce));
            if (byte_rev(d) < model_target(target_in)) begin
                h.edge_no = e + 130; h.res = d; h.t = m_time; h.n = m_nonce;
                q.push_back(h);
            end
            if (m_nonce == 32'hFFFFFFFF) m_time = m_time + 32'd1;
            m_nonce = m_nonce + 32'd1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n, input logic we_v);
        for (int i = 0; i < n; i++) step(1'b1, we_v);
    endtask

    task automatic known_setup();
        digest_intial = 256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
        digest_in     = 256'hF7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776;
        merkle_in = 32'h252db801; time_in = 32'h130dae51;
        target_in = 32'h6461011a; nonce_in = 32'h3aeb9bb0;
    endtask

    initial begin
        RST = 1'b0; write_en = 1'b0;
        digest_intial = 256'd0; digest_in = 256'd0;
        merkle_in = 32'd0; time_in = 32'd0; target_in = 32'd0; nonce_in = 32'd0;

        // Model sanity against the published known-block values.
        known_setup();
        chk("model_stage_a_b0", model_stage_a(32'h130dae51, 32'h3aeb9bb0),
            256'hD113D3BB65EAEED1EBA29A6E06640A8CFD2394C1672229D878D8CEACD8C824A2);
        chk("model_final_b0", model_final(model_stage_a(32'h130dae51, 32'h3aeb9bb0)),
            256'h4FC234738E7F3AC09F4432A23EAB1E707578A6310F0EB320515D61001CB18E75);
        chk("model_final_b1", model_final(model_stage_a(32'h130dae51, 32'h3aeb9bb1)),
            256'hCCA2649D234850E0FD84EDB32B06AE3E415E85F5D19A59622B91F8607B948287);
        chk("model_final_b8", model_final(model_stage_a(32'h130dae51, 32'h3aeb9bb8)),
            256'h5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000);

        // Counter wrap with a near-max target so nearly every candidate reports.
        digest_intial = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        digest_in     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        merkle_in = $urandom; time_in = 32'hAAAAAAA1; nonce_in = 32'hFFFFFFF0;
        target_in = 32'hFFFFFF20;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        run(20, 1'b1); run(140, 1'b0);

        // Known block: single hit on nonce ...b8.
        known_setup();
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        run(9, 1'b1); run(140, 1'b0);

        // Reset flush: the pending ...b8 hit must never appear; then restart.
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        run(9, 1'b1); run(60, 1'b0);
        step(1'b0, 1'b0);
        run(140, 1'b0);
        run(9, 1'b1); run(140, 1'b0);

        // write_en gap of 5 edges: hit delayed by 5.
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        run(5, 1'b1); run(5, 1'b0); run(4, 1'b1); run(140, 1'b0);

        // Randomized phases with mixed targets and occasional mid-run resets.
        for (int p = 0; p < 6; p++) begin
            logic [23:0] mant;
            digest_intial = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            digest_in     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            merkle_in = $urandom; time_in = $urandom;
            nonce_in  = 32'hFFFFFFFF - $urandom_range(0, 60);
            mant = 24'($urandom);
            case (p)
                3:       target_in = {mant[7:0], mant[15:8], mant[23:16], 8'h21};
                4:       target_in = {mant[7:0], mant[15:8], mant[23:16], 8'h02};
                5:       target_in = {8'hFF, 8'hFF, 8'hFF, 8'h1F};
                default: target_in = {mant[7:0], mant[15:8], mant[23:16], 8'h20};
            endcase
            step(1'b0, 1'b0);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 63) == 0) begin
                    time_in = $urandom; nonce_in = $urandom;
                    step(1'b0, 1'b1);
                end else begin
                    step(1'b1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
                end
            end
            run(140, 1'b0);
        end

        chk("queue_drained", {224'd0, 32'(q.size())}, 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_hasher.md
Name: sha_hasher

Overview:
- Bitcoin proof-of-work search engine. Iterates nonce/time over a fixed block-header tail and computes SHA256d, fully pipelined with one candidate per clock.
- Reports candidates whose hash meets the compact target.
- Sits behind the host interface, which supplies the first-chunk midstate and header-tail fields.

Parameters:
- none

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset; also the load strobe for the search start values
- write_en  in  1  run enable; 1 = inject one candidate per clock
- digest_intial  in  256  H0..H7 after chunk 1 (H0 in MSBs); added to chunk-2 working state at the end
- digest_in  in  256  chunk-2 working state a..h (a in MSBs), already advanced through round 0 (W0 constant)
- merkle_in  in  32  chunk-2 W0
- time_in  in  32  start time, chunk-2 W1
- target_in  in  32  compact nBits as header bytes; nBits = byte-reverse(target_in)
- nonce_in  in  32  start nonce, chunk-2 W3
- valid_out  out  1  one-cycle pulse when a new hit is registered
- time_out  out  32  time of last hit
- nonce_out  out  32  nonce of last hit
- result_out  out  256  final digest H0..H7 of last hit (H0 in MSBs)

Behaviour:
- Reset (RST=0 at an edge):
  - time_counter_reg <= time_in; nonce_counter_reg <= nonce_in.
  - Clear all pipeline valid bits.
  - valid_out, time_out, nonce_out, result_out <= 0.
  - Data pipeline registers are not reset.
- Run (RST=1, write_en=1), each edge:
  - Inject (time_counter_reg, nonce_counter_reg) with valid=1.
  - nonce_counter_reg += 1 (mod 2^32).
  - If nonce_counter_reg == FFFFFFFF at that edge, time_counter_reg += 1 (mod 2^32).
- write_en=0: counters hold; the injected slot is marked invalid.
- Stage A, chunk 2:
  - Message: W0=merkle_in, W1=time, W2=nBits word (target_in), W3=nonce, W4=80000000, W5..W14=0, W15=00000280.
  - Start from digest_in; run rounds 1..63; add digest_intial word-wise.
- Stage B, second SHA-256:
  - Message: stage-A digest (8 words), 80000000, 6 zero words, 00000100.
  - Standard IV; 64 rounds; add IV.
- Pipeline: fully unrolled, one round per register stage. Schedule words are carried along with the state, so throughput is one candidate per clock. Nonce, time and valid travel alongside the data.
- Latency (candidate captured at edge k):
  - Stage-A digest registered at edge k+64.
  - Final digest and output update at edge k+130.
- Target decode:
  - E = nBits[31:24], M = nBits[23:0], T = M << 8*(E-3).
  - If E < 3, right-shift instead.
  - E > 32 saturates T to all-ones above bit 255.
- Hit test:
  - hash_num = byte-reverse of the 256-bit final digest.
  - Hit iff valid and hash_num < T (unsigned 256-bit compare, combinational, before the output register).
- On hit, at the same edge: result_out <= final digest, nonce_out/time_out <= carried values, valid_out <= 1.
- Otherwise valid_out <= 0 and the other outputs hold the last hit indefinitely, until reset or a new hit.
- Reset mid-run: in-flight candidates are invalidated and can never produce a hit. The new search starts from the newly loaded counters.

Test Plan:
- Counter wrap: time_in=AAAAAAA1, nonce_in=FFFFFFF0, hold reset 2 edges, release. Immediately: counters AAAAAAA1/FFFFFFF0. After 17 run edges: nonce=00000001, time=AAAAAAA2.
- Known block, common setup:
  - digest_intial = F59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771
  - digest_in = F7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776
  - merkle_in=252db801, time_in=130dae51, target_in=6461011a, nonce_in=3aeb9bb0
- Known block, stage A: nonce 3aeb9bb0 captured at edge 1 gives stage-A digest D113D3BB65EAEED1EBA29A6E06640A8CFD2394C1672229D878D8CEACD8C824A2 after edge 65.
- Known block, stage B:
  - Final digest for 3aeb9bb0 = 4FC234738E7F3AC09F4432A23EAB1E707578A6310F0EB320515D61001CB18E75 after edge 131.
  - Final digest for 3aeb9bb1 = CCA2649D234850E0FD84EDB32B06AE3E415E85F5D19A59622B91F8607B948287 one cycle later.
  - No hit for nonces ...b0 to ...b7; outputs stay 0.
- Known block, hit: after edge 139, result_out=5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000, nonce_out=3aeb9bb8, time_out=130dae51, valid_out pulses 1 cycle. Values hold on following edges.
- Reset flush: assert RST for 1 edge during the run above. Outputs clear to 0; no hit appears from pre-reset candidates.
- write_en=0 for 5 edges: counters frozen; results are delayed by exactly 5 cycles with no duplicate hits.
